// File: rtl/reg_bank_param.sv
// reg_bank_param
//   Parametrised register bank: DATA_W-bit words, 2**ADDR_W entries, two
//   registered read ports and one write port. After reset, a hardware sweep
//   writes INIT_VAL into every entry, so the array needs no per-bit reset
//   and can map onto block RAM. The bank ignores all requests until the sweep
//   has finished.
//
//   Optional feature (macro REG_BANK_ZERO_REG_EN): entry 0 is hardwired to
//   zero. Writes to it are dropped, and reads or forwards from it return 0.
//
// Ports
//   clk                  clock; all state updates on the rising edge
//   reset                synchronous, active-low reset
//   readReg1/readReg2    read addresses
//   readEn1/readEn2      read requests
//   writeReg             write address
//   writeData            write data
//   regWrite             write enable
//   readData1/readData2  registered read data (held when not read)
//   readValid1/2         read data updated on this cycle
//   ready                init sweep complete; bank in service
//
// Handshake: a read request is accepted on any rising edge where ready==1
// and readEnN==1. Its data appears on readDataN one cycle later, qualified
// by readValidN. Requests that arrive while ready==0 are dropped, not queued.
module reg_bank_param #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 3,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   input  logic              readEn1,
   input  logic              readEn2,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0] writeData,
   input  logic              regWrite,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              readValid1,
   output logic              readValid2,
   output logic              ready
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic              run;
   logic [DATA_W-1:0] rd1_word, rd2_word;

   assign run   = (state_q == ST_RUN);
   assign ready = run;

   // Next-state logic and selection of the write port source: the sweep
   // writes during INIT, and the user writes during RUN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mem_we  = 1'b0;
      mem_wa  = writeReg;
      mem_wd  = writeData;
      case (state_q)
         ST_INIT: begin
            mem_we = 1'b1;
            mem_wa = idx_q;
            mem_wd = INIT_VAL;
            idx_d  = idx_q + 1'b1;
            if (&idx_q) state_d = ST_RUN;
         end
         ST_RUN: begin
`ifdef REG_BANK_ZERO_REG_EN
            mem_we = regWrite && (writeReg != '0);
`else
            mem_we = regWrite;
`endif
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Read data with write-to-read forwarding. A same-cycle write to the
   // address being read wins over the old array contents.
   always_comb begin
      rd1_word = (regWrite && (writeReg == readReg1)) ? writeData : mem[readReg1];
      rd2_word = (regWrite && (writeReg == readReg2)) ? writeData : mem[readReg2];
`ifdef REG_BANK_ZERO_REG_EN
      if (readReg1 == '0) rd1_word = '0;
      if (readReg2 == '0) rd2_word = '0;
`endif
   end

   // The storage array has no reset: reset only blocks the write.
   always_ff @(posedge clk) begin
      if (reset && mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_INIT;
         idx_q      <= '0;
         readData1  <= '0;
         readData2  <= '0;
         readValid1 <= 1'b0;
         readValid2 <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         readValid1 <= run && readEn1;
         readValid2 <= run && readEn2;
         if (run && readEn1) readData1 <= rd1_word;
         if (run && readEn2) readData2 <= rd2_word;
      end
   end

endmodule

// File: tb/tb_reg_bank_param.sv
module tb_reg_bank_param;

   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 3;
   localparam int          DEPTH  = 8;
   localparam logic [31:0] INIT   = 32'hA5A5A5A5;
`ifdef REG_BANK_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  readReg1, readReg2, writeReg;
   logic        readEn1, readEn2, regWrite;
   logic [31:0] writeData;
   logic [31:0] readData1, readData2;
   logic        readValid1, readValid2, ready;

   always #5 clk = ~clk;

   reg_bank_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(INIT)) dut (
      .clk(clk), .reset(reset),
      .readReg1(readReg1), .readReg2(readReg2),
      .readEn1(readEn1), .readEn2(readEn2),
      .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
      .readData1(readData1), .readData2(readData2),
      .readValid1(readValid1), .readValid2(readValid2),
      .ready(ready)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Behavioural view: DEPTH cycles after reset is released, the whole bank
   // becomes INIT. After that, each request is served from the array with
   // same-cycle writes taking priority.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_rd1, m_rd2;
   logic        m_v1, m_v2;
   bit          m_rdy = 1'b0;
   int          m_cnt = 0;

   function automatic logic [31:0] model_read(input logic [2:0] a);
      if (ZR && a == 3'd0) return 32'd0;
      if (regWrite && writeReg == a) return writeData;
      return m_mem[a];
   endfunction

   task automatic model_step();
      if (!reset) begin
         m_rd1 = 0; m_rd2 = 0; m_v1 = 0; m_v2 = 0; m_rdy = 0; m_cnt = 0;
      end else if (!m_rdy) begin
         m_v1 = 0; m_v2 = 0;
         m_cnt++;
         if (m_cnt == DEPTH) begin
            foreach (m_mem[i]) m_mem[i] = INIT;
            m_rdy = 1;
         end
      end else begin
         m_v1 = readEn1;
         m_v2 = readEn2;
         if (readEn1) m_rd1 = model_read(readReg1);
         if (readEn2) m_rd2 = model_read(readReg2);
         if (regWrite && !(ZR && writeReg == 3'd0)) m_mem[writeReg] = writeData;
      end
   endtask

   task automatic compare_model();
      check("model_rd1", readData1, m_rd1);
      check("model_rd2", readData2, m_rd2);
      check("model_v1", {31'd0, readValid1}, {31'd0, m_v1});
      check("model_v2", {31'd0, readValid2}, {31'd0, m_v2});
      check("model_ready", {31'd0, ready}, {31'd0, m_rdy});
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs, lets the edge happen, and samples 1 ns later.
   task automatic apply(input logic rst, input logic we, input logic [2:0] wa,
                        input logic [31:0] wd, input logic e1, input logic [2:0] r1,
                        input logic e2, input logic [2:0] r2);
      reset = rst; regWrite = we; writeReg = wa; writeData = wd;
      readEn1 = e1; readReg1 = r1; readEn2 = e2; readReg2 = r2;
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic idle(input logic rst);
      apply(rst, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic        e1;
      logic [2:0]  r1;
      logic        e2;
      logic [2:0]  r2;
      logic [31:0] x1;
      logic        xv1;
      logic [31:0] x2;
      logic        xv2;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [31:0] z_or_f;
      z_or_f = ZR ? 32'd0 : 32'hFFFFFFFF;
      reset = 1'b0; regWrite = 0; writeReg = 0; writeData = 0;
      readEn1 = 0; readReg1 = 0; readEn2 = 0; readReg2 = 0;

      // -------- init sweep: reset low 2 cycles, ready rises after 8th edge
      idle(1'b0);
      idle(1'b0);
      check("reset_rd1", readData1, 32'd0);
      check("reset_v1", {31'd0, readValid1}, 32'd0);
      check("reset_ready", {31'd0, ready}, 32'd0);
      for (int k = 1; k <= DEPTH; k++) begin
         idle(1'b1);
         check($sformatf("sweep_ready_c%0d", k), {31'd0, ready}, {31'd0, (k == DEPTH)});
      end
      for (int a = 0; a < DEPTH; a++) begin
         apply(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 3'(a), 1'b1, 3'(a));
         check($sformatf("init_rd1_a%0d", a), readData1, (ZR && a == 0) ? 32'd0 : INIT);
         check($sformatf("init_rd2_a%0d", a), readData2, (ZR && a == 0) ? 32'd0 : INIT);
         check($sformatf("init_v1_a%0d", a), {31'd0, readValid1}, 32'd1);
      end

      // -------- table: write/read, forwarding, zero register, hold
      //           we  wa    wd            e1 r1    e2 r2    x1            v1 x2            v2
      vecs[0] = '{1'b1, 3'd5, 32'h12345678, 1'b0, 3'd0, 1'b0, 3'd0, INIT,         1'b0, INIT,         1'b0};
      vecs[1] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd5, 1'b0, 3'd0, 32'h12345678, 1'b1, INIT,         1'b0};
      vecs[2] = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 3'd3, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
      vecs[3] = '{1'b1, 3'd3, 32'h0BADF00D, 1'b1, 3'd4, 1'b1, 3'd3, INIT,         1'b1, 32'h0BADF00D, 1'b1};
      vecs[4] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd3, 1'b1, 3'd5, 32'h0BADF00D, 1'b1, 32'h12345678, 1'b1};
      vecs[5] = '{1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd0, 1'b1, 3'd0, z_or_f,       1'b1, z_or_f,       1'b1};
      vecs[6] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd0, 1'b1, 3'd0, z_or_f,       1'b1, z_or_f,       1'b1};
      vecs[7] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd1, 1'b0, 3'd2, z_or_f,       1'b0, z_or_f,       1'b0};
      foreach (vecs[i]) begin
         apply(1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].e1, vecs[i].r1, vecs[i].e2, vecs[i].r2);
         check($sformatf("vec%0d_rd1", i), readData1, vecs[i].x1);
         check($sformatf("vec%0d_v1", i), {31'd0, readValid1}, {31'd0, vecs[i].xv1});
         check($sformatf("vec%0d_rd2", i), readData2, vecs[i].x2);
         check($sformatf("vec%0d_v2", i), {31'd0, readValid2}, {31'd0, vecs[i].xv2});
      end

      // -------- reset in RUN: write reg 2, pulse reset, reg 2 returns INIT
      apply(1'b1, 1'b1, 3'd2, 32'h1, 1'b1, 3'd2, 1'b0, 3'd0);
      check("run_fwd_reg2", readData1, 32'h1);
      idle(1'b0);
      check("runrst_rd1", readData1, 32'd0);
      check("runrst_rd2", readData2, 32'd0);
      check("runrst_v1", {31'd0, readValid1}, 32'd0);
      check("runrst_ready", {31'd0, ready}, 32'd0);

      // -------- reset mid-sweep, with write and read pulses during INIT
      for (int k = 0; k < 3; k++)
         apply(1'b1, 1'b1, 3'(k), 32'hCAFE0000 + 32'(k), 1'b1, 3'(k), 1'b1, 3'(k));
      check("midsweep_ready", {31'd0, ready}, 32'd0);
      check("midsweep_v1", {31'd0, readValid1}, 32'd0);
      idle(1'b0);
      for (int k = 1; k <= DEPTH; k++) begin
         apply(1'b1, 1'b1, 3'(k % DEPTH), $urandom, 1'b1, 3'(k % DEPTH), 1'b0, 3'd0);
         check($sformatf("resweep_ready_c%0d", k), {31'd0, ready}, {31'd0, (k == DEPTH)});
         check($sformatf("resweep_rd1_c%0d", k), readData1, 32'd0);
      end
      for (int a = 0; a < DEPTH; a++) begin
         apply(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 3'(a), 1'b0, 3'd0);
         check($sformatf("resweep_clean_a%0d", a), readData1, (ZR && a == 0) ? 32'd0 : INIT);
      end

      // -------- randomized traffic against the model, occasional resets
      for (int n = 0; n < 400; n++) begin
         logic [31:0] wd;
         wd = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
         apply($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wd,
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised successor to the fixed 8x32 register bank: DATA_W-bit wide, 2**ADDR_W deep, two synchronous read ports and one write port.
- Adds a hardware initialisation sweep after reset, so the array maps onto block RAM instead of a flop-per-bit reset.
- Adds a `ready` flag, per-port read-valid strobes and write-to-read forwarding.
- Sits between instruction decode and the ALU in the datapath.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W.
- INIT_VAL, 0, value written to every entry by the init sweep (DATA_W bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- readReg1  in  ADDR_W  read port 1 address.
- readReg2  in  ADDR_W  read port 2 address.
- readEn1  in  1  read port 1 request.
- readEn2  in  1  read port 2 request.
- writeReg  in  ADDR_W  write address.
- writeData  in  DATA_W  write data.
- regWrite  in  1  write enable.
- readData1  out  DATA_W  registered read data, port 1.
- readData2  out  DATA_W  registered read data, port 2.
- readValid1  out  1  readData1 updated this cycle.
- readValid2  out  1  readData2 updated this cycle.
- ready  out  1  init sweep complete; bank accepts reads and writes.

Behaviour:
- Reset: sampled on the rising edge of clk while reset==0. Outputs then take these values: readData1/2=0, readValid1/2=0, ready=0, FSM=INIT, sweep index idx=0. Array contents are not touched by reset itself.
- Reset asserted mid-sweep or mid-RUN: the same values are applied. The sweep restarts from idx=0 once reset returns to 1.
- FSM INIT:
  - Each cycle with reset==1, write INIT_VAL to entry idx, then idx++.
  - After the cycle that writes entry DEPTH-1, go to RUN and set ready=1 on that same edge.
  - The sweep takes exactly DEPTH cycles after reset deassertion.
  - In INIT, regWrite, readEn1 and readEn2 are ignored; readValid1/2 stay 0 and readData1/2 hold 0.
- FSM RUN:
  - No exit except reset; ready stays 1.
- Write (RUN only): if regWrite==1, entry writeReg takes writeData at the rising edge.
- Read, port n (RUN only):
  - If readEnn==1, at the rising edge readDatan = entry readRegn and readValidn=1. Latency is 1 cycle.
  - If readEnn==0, readDatan holds its previous value and readValidn=0.
- Forwarding: if regWrite==1, readEnn==1 and writeReg==readRegn in the same cycle, readDatan = writeData (new data, not old contents). Applies independently per port; both ports may forward at once.
- Both ports may read the same address in the same cycle; both return identical data.
- Addresses are always in range (width-bounded); there is no out-of-range case.

Optional Feature:
- Macro: REG_BANK_ZERO_REG_EN
- Defined:
  - Entry 0 reads as 0 at all times.
  - Writes to writeReg==0 are discarded, and forwarding to address 0 returns 0.
  - The init sweep still visits entry 0 but the result is irrelevant.
- Undefined: entry 0 is an ordinary register, written and read like any other.

Test Plan:
- Init sweep: DATA_W=32, ADDR_W=3, INIT_VAL=32'hA5A5A5A5; reset low 2 cycles, then high -> ready=0 for cycles 1-7, ready=1 after the 8th edge. A read of each address 0..7 then returns A5A5A5A5 with readValid=1 one cycle after readEn.
- Write/read: in RUN, write 32'h12345678 to reg 5; next cycle read reg 5 on port 1 -> readData1=12345678, readValid1=1 one cycle later. Port 2 idle -> readValid2=0, readData2 unchanged.
- Forwarding: same cycle write 32'hDEADBEEF to reg 3 and read reg 3 on both ports -> both readData=DEADBEEF next cycle. Same cycle read reg 4 while writing reg 3 -> old contents of reg 4.
- Reset mid-sweep: deassert reset, wait 3 cycles, assert reset 1 cycle, deassert -> ready rises exactly 8 cycles after the second deassertion. regWrite pulses during INIT leave no trace after the sweep.
- Reset in RUN: write 32'h1 to reg 2, then pulse reset low 1 cycle -> readData1/2=0, readValid=0, ready=0. After the sweep, reg 2 reads INIT_VAL.
- With REG_BANK_ZERO_REG_EN: write 32'hFFFFFFFF to reg 0 while reading reg 0 -> readData=0 on both the forwarded and the following plain read. Without the macro -> FFFFFFFF on both.
